e_mdu: RTL

//   Parametrised multi-cycle multiply/divide unit in the E stage, beside the E-stage ALU.

---
 rtl/e_mdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: mult/div/madd/msub into HI/LO, plus single-cycle mthi/mtlo.
// Latency: MUL_LAT cycles for multiply-class ops, DIV_LAT for divides; mthi/mtlo commit at the issue edge.
// Backpressure: busy (registered) is high while an op is in flight; starts seen while busy are dropped.
module e_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_base;

  // Issue/commit qualifiers; flush wins over both.
  logic w_idle_start, w_issue, w_done, w_mthi, w_mtlo, w_issue_div;
  logic [CW-1:0] w_lat_m1;

  assign w_idle_start = start && !flush && (r_state == S_IDLE);
  assign w_issue      = w_idle_start && (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
  assign w_mthi       = w_idle_start && (md_op == OP_MTHI);
  assign w_mtlo       = w_idle_start && (md_op == OP_MTLO);
  assign w_done       = !flush && (r_state == S_RUN) && (r_cnt == '0);
  assign w_issue_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign w_lat_m1     = w_issue_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  // State and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: flush aborts, IDLE accepts an issue, RUN counts down to the commit edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = w_lat_m1;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Result datapath works on the latched operands; it is only looked at on the commit edge.
  logic w_sgn;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_acc;
  logic w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag, w_quo, w_rem;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  assign w_sgn   = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD) || (r_op == OP_MSUB);
  assign w_a_ext = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
  // Low 2*WIDTH bits of the product of extended operands give the exact signed or unsigned product.
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_acc   = ((r_op == OP_MSUB) || (r_op == OP_MSUBU)) ? (r_base - w_prod) : (r_base + w_prod);

  // Divide by magnitudes; the most-negative / -1 case falls out as quotient 0x80..0, remainder 0.
  assign w_a_neg  = w_sgn & r_a[WIDTH-1];
  assign w_b_neg  = w_sgn & r_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;
  assign w_b_zero = (r_b == '0);
  // Divisor forced to 1 on divide-by-zero so the divider never sees 0; that result is overridden.
  assign w_b_div  = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_div;
  assign w_r_mag  = w_a_mag % w_b_div;
  assign w_quo    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_rem    = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

  // Select the HI/LO pair to commit for the latched op.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT, OP_MULTU: begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
      end
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        w_res_hi = w_acc[2*WIDTH-1:WIDTH];
        w_res_lo = w_acc[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        if (w_b_zero) begin
          w_res_hi = r_a;
          w_res_lo = '1;
        end else begin
          w_res_hi = w_rem;
          w_res_lo = w_quo;
        end
      end
      default: ;
    endcase
  end

  // Operand/base latches on issue; HI/LO written on commit or by mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_base <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_issue) begin
        r_a    <= A;
        r_b    <= B;
        r_op   <= md_op;
        r_base <= {r_hi, r_lo};
      end
      if (w_done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_mthi) r_hi <= A;
        if (w_mtlo) r_lo <= A;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
